uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 tb/tb_uart_rx_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer between a UART receiver and a host.
// Each character is stored with its framing-error and end-of-message tags. The host
// reads through a first-word-fall-through valid/ready port. The block also reports
// the fill level, the number of complete messages held, almost-full, and a sticky
// overflow flag.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_data/rx_valid    receiver character and its one-cycle strobe
//   rx_frame_err/rx_eom receiver tags, stored with the character
//   m_data/m_frame_err  head entry, zero when m_valid is low
//   m_eom/m_valid       head end-of-message tag, head valid
//   m_ready             host accepts the head this cycle
//   level, msg_count    entries stored, stored entries tagged eom
//   almost_full         level >= AFULL_LEVEL
//   overflow/ovf_clear  sticky drop flag and its clear
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_frame_err,
  input  logic                     rx_eom,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_frame_err,
  output logic                     m_eom,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   msg_count,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_LEVEL);

  // Entry layout: {eom, frame_err, data}
  logic [DATA_WIDTH+1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       level_q, level_d;
  logic [CntW-1:0]       msg_q, msg_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH+1:0] head;
  logic                  push, pop, drop, valid;

  always_comb begin
    head  = mem_q[rd_ptr_q];
    valid = (level_q != '0);
    pop   = valid & m_ready;
    // A full FIFO still accepts a character when the head leaves in the same cycle.
    push  = rx_valid & ((level_q != DepthCnt) | pop);
    drop  = rx_valid & ~push;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + CntW'(1);
    end else if (pop && !push) begin
      level_d = level_q - CntW'(1);
    end

    msg_d = msg_q;
    unique case ({push & rx_eom, pop & head[DATA_WIDTH+1]})
      2'b10:   msg_d = msg_q + CntW'(1);
      2'b01:   msg_d = msg_q - CntW'(1);
      default: msg_d = msg_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      msg_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
      msg_q   <= msg_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is deliberately not reset; m_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= {rx_eom, rx_frame_err, rx_data};
    end
  end

  always_comb begin
    m_valid     = valid;
    m_data      = valid ? head[DATA_WIDTH-1:0] : '0;
    m_frame_err = valid & head[DATA_WIDTH];
    m_eom       = valid & head[DATA_WIDTH+1];
    level       = level_q;
    msg_count   = msg_q;
    almost_full = (level_q >= AfullCnt);
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed sequences then randomized traffic. The driver
// keeps a queue-based reference model and pushes each accepted character into a
// scoreboard; a monitor on the falling edge compares outputs and pops on handshakes.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_frame_err = 1'b0;
  logic          rx_eom = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_frame_err;
  logic          m_eom;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] level;
  logic [CW-1:0] msg_count;
  logic          almost_full;
  logic          overflow;
  logic          ovf_clear = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_eom      (rx_eom),
    .m_data      (m_data),
    .m_frame_err (m_frame_err),
    .m_eom       (m_eom),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .msg_count   (msg_count),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clear   (ovf_clear)
  );

  logic [DW+1:0] mdl_q[$];  // reference FIFO contents {eom, fe, data}
  logic [DW+1:0] sb_q[$];   // expected output order, consumed by the monitor
  int  cur_level = 0, nxt_level = 0;
  int  cur_msgs = 0, nxt_msgs = 0;
  bit  cur_ovf = 0, nxt_ovf = 0;
  bit  started = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, predict the state after the next rising edge, then
  // wait for that edge.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit fe, input bit eom,
                      input bit rdy, input bit clr, input bit rst);
    bit pop, push;
    rx_valid     = v;
    rx_data      = d;
    rx_frame_err = fe;
    rx_eom       = eom;
    m_ready      = rdy;
    ovf_clear    = clr;
    rst_n        = rst;
    if (!rst) begin
      mdl_q.delete();
      sb_q.delete();
      nxt_level = 0;
      nxt_msgs  = 0;
      nxt_ovf   = 0;
    end else begin
      pop  = rdy && (mdl_q.size() > 0);
      push = v && ((mdl_q.size() < DEPTH) || pop);
      nxt_msgs = cur_msgs;
      if (pop) begin
        if (mdl_q[0][DW+1]) nxt_msgs--;
        void'(mdl_q.pop_front());
      end
      if (push) begin
        mdl_q.push_back({eom, fe, d});
        sb_q.push_back({eom, fe, d});
        if (eom) nxt_msgs++;
      end
      nxt_level = mdl_q.size();
      nxt_ovf   = (v && !push) ? 1'b1 : (clr ? 1'b0 : cur_ovf);
    end
    @(posedge clk);
    #1;
    cur_level = nxt_level;
    cur_msgs  = nxt_msgs;
    cur_ovf   = nxt_ovf;
    started   = 1;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, '0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
  endtask

  // Monitor: inputs and outputs are both stable at the falling edge.
  always @(negedge clk) begin
    if (started && rst_n) begin
      check("level", int'(level), cur_level);
      check("msg_count", int'(msg_count), cur_msgs);
      check("almost_full", int'(almost_full), int'(cur_level >= AFULL));
      check("overflow", int'(overflow), int'(cur_ovf));
      check("m_valid", int'(m_valid), int'(cur_level != 0));
      if (m_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: m_valid=1 but no character expected at %0t", $time);
        end else begin
          check("m_data", int'(m_data), int'(sb_q[0][DW-1:0]));
          check("m_frame_err", int'(m_frame_err), int'(sb_q[0][DW]));
          check("m_eom", int'(m_eom), int'(sb_q[0][DW+1]));
          if (m_ready) void'(sb_q.pop_front());
        end
      end else begin
        check("idle_outputs", int'({m_eom, m_frame_err, m_data}), 0);
      end
    end
  end

  initial begin
    int rdy_pct;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Three characters, middle one ends a message, then drain.
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b0);

    // Fill to DEPTH, drop one, then push and pop together while full.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // Drop coinciding with clear keeps overflow; a lone clear then releases it.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i + 16), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);

    // Both tags on one entry, then reset with a push pending.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Randomized traffic with phases of varying host readiness.
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) rdy_pct = 10 * int'($urandom_range(10, 0));
      step($urandom_range(99) < 65, 8'($urandom), 1'($urandom), ($urandom_range(3) == 0),
           $urandom_range(99) < rdy_pct, ($urandom_range(9) == 0),
           ($urandom_range(299) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
